// File: rtl/router_pkt_reader.sv
// Destination-side packet reader: drains a router FIFO, parses the header,
// streams payload bytes to the sink and checks the trailing parity byte.
module router_pkt_reader #(
    parameter logic [1:0] PORT_ADDR = 2'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       soft_reset,
    input  logic       vld_out,
    input  logic [7:0] data_out,
    input  logic       hold,
    output logic       read_enb,
    output logic       busy,
    output logic       hdr_valid,
    output logic [5:0] pkt_len,
    output logic [1:0] pkt_addr,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       byte_last,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       addr_err
);
    localparam int unsigned CntW  = 7;
    localparam int unsigned ByteW = 8;
    localparam int unsigned LenW  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q,      state_d;
    logic [CntW-1:0]   req_left_q,   req_left_d;
    logic [CntW-1:0]   rcv_left_q,   rcv_left_d;
    logic [ByteW-1:0]  acc_q,        acc_d;
    logic [ByteW-1:0]  byte_out_q,   byte_out_d;
    logic [LenW-1:0]   pkt_len_q,    pkt_len_d;
    logic [1:0]        pkt_addr_q,   pkt_addr_d;
    logic              rd_pend_q,    rd_pend_d;
    logic              busy_q,       busy_d;
    logic              hdr_valid_q,  hdr_valid_d;
    logic              byte_valid_q, byte_valid_d;
    logic              byte_last_q,  byte_last_d;
    logic              pkt_done_q,   pkt_done_d;
    logic              parity_err_q, parity_err_d;
    logic              addr_err_q,   addr_err_d;
    logic              rd_c;

    // Next-state, read strobe and capture logic
    always_comb begin
        state_d      = state_q;
        req_left_d   = req_left_q;
        rcv_left_d   = rcv_left_q;
        acc_d        = acc_q;
        byte_out_d   = byte_out_q;
        pkt_len_d    = pkt_len_q;
        pkt_addr_d   = pkt_addr_q;
        parity_err_d = parity_err_q;
        addr_err_d   = addr_err_q;
        rd_pend_d    = 1'b0;
        hdr_valid_d  = 1'b0;
        byte_valid_d = 1'b0;
        byte_last_d  = 1'b0;
        pkt_done_d   = 1'b0;
        rd_c         = 1'b0;

        case (state_q)
            IDLE: begin
                rd_c = vld_out & ~hold;
                if (rd_c) state_d = HDR;
            end
            HDR: begin
                pkt_len_d    = data_out[7:2];
                pkt_addr_d   = data_out[1:0];
                hdr_valid_d  = 1'b1;
                req_left_d   = CntW'(data_out[7:2]) + CntW'(1);
                rcv_left_d   = CntW'(data_out[7:2]) + CntW'(1);
                acc_d        = data_out;
                parity_err_d = 1'b0;
                addr_err_d   = 1'b0;
                state_d      = BODY;
            end
            BODY: begin
                rd_c      = vld_out & ~hold & (req_left_q != CntW'(0));
                rd_pend_d = rd_c;
                if (rd_c) req_left_d = req_left_q - CntW'(1);
                // A read issued last cycle delivers its byte now
                if (rd_pend_q) begin
                    rcv_left_d = rcv_left_q - CntW'(1);
                    if (rcv_left_q > CntW'(1)) begin
                        acc_d        = acc_q ^ data_out;
                        byte_out_d   = data_out;
                        byte_valid_d = 1'b1;
                        byte_last_d  = (rcv_left_q == CntW'(2));
                    end else begin
                        parity_err_d = (data_out != acc_q);
                        addr_err_d   = (pkt_addr_q != PORT_ADDR);
                        pkt_done_d   = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort the packet in progress; header fields and error flags survive
        if (soft_reset) begin
            rd_c         = 1'b0;
            state_d      = IDLE;
            req_left_d   = '0;
            rcv_left_d   = '0;
            acc_d        = '0;
            rd_pend_d    = 1'b0;
            hdr_valid_d  = 1'b0;
            byte_valid_d = 1'b0;
            byte_last_d  = 1'b0;
            pkt_done_d   = 1'b0;
            pkt_len_d    = pkt_len_q;
            pkt_addr_d   = pkt_addr_q;
            parity_err_d = parity_err_q;
            addr_err_d   = addr_err_q;
        end

        busy_d   = (state_d != IDLE);
        read_enb = rd_c & ~reset;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            req_left_q   <= '0;
            rcv_left_q   <= '0;
            acc_q        <= '0;
            byte_out_q   <= '0;
            pkt_len_q    <= '0;
            pkt_addr_q   <= '0;
            rd_pend_q    <= 1'b0;
            busy_q       <= 1'b0;
            hdr_valid_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_left_q   <= req_left_d;
            rcv_left_q   <= rcv_left_d;
            acc_q        <= acc_d;
            byte_out_q   <= byte_out_d;
            pkt_len_q    <= pkt_len_d;
            pkt_addr_q   <= pkt_addr_d;
            rd_pend_q    <= rd_pend_d;
            busy_q       <= busy_d;
            hdr_valid_q  <= hdr_valid_d;
            byte_valid_q <= byte_valid_d;
            byte_last_q  <= byte_last_d;
            pkt_done_q   <= pkt_done_d;
            parity_err_q <= parity_err_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign busy       = busy_q;
    assign hdr_valid  = hdr_valid_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_addr   = pkt_addr_q;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign byte_last  = byte_last_q;
    assign pkt_done   = pkt_done_q;
    assign parity_err = parity_err_q;
    assign addr_err   = addr_err_q;

endmodule
